// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state encodings,
// SRAM transfer size code and the fetch exception code.
package if_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_CANCEL = 3'd3,
    S_FULL   = 3'd4
  } fetch_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [4:0] EXC_ADEL  = 5'h04;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction-cache read bus between the fetch stage (master) and
// the I-cache (slave).
interface if_fetch_ctrl_if #(
  parameter int N  = 32,
  parameter int DW = 32
);
  logic          inst_req;
  logic [N-1:0]  inst_addr;
  logic [1:0]    inst_size;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr, inst_size,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr, inst_size,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl_inst_buf.sv
// One-entry IF/ID output buffer: holds a fetched instruction or a misaligned
// fetch marker until ID consumes it or a flush drops it.
module if_fetch_ctrl_inst_buf #(
  parameter int N  = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [N-1:0]  ld_pc,
  input  logic [DW-1:0] ld_inst,
  input  logic          ld_adel,
  output logic          valid,
  output logic [N-1:0]  pc,
  output logic [DW-1:0] inst,
  output logic          adel
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
      adel  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
      adel  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= ld_pc;
      inst  <= ld_inst;
      adel  <= ld_adel;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage: one cache read per pc, PC advance enable, flush
// cancellation of an outstanding read and misaligned-fetch detection.
//
//   state    | meaning
//   S_IDLE   | first cycle after reset, no request
//   S_REQ    | presenting pc to the cache until addr_ok
//   S_WAIT   | request accepted, waiting for data_ok
//   S_CANCEL | flushed while waiting, drop the returning data
//   S_FULL   | output buffer holds an entry for ID
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int N  = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    pc,
  input  logic            fpc,
  input  logic            flush_except,
  input  logic            id_allowin,
  output logic            pc_en,
  if_fetch_ctrl_if.master ibus,
  output logic            if_valid,
  output logic [N-1:0]    if_pc,
  output logic [DW-1:0]   if_inst,
  output logic            if_adel
);

  fetch_state_e  state;
  logic [N-1:0]  pend_pc;
  logic          aligned;
  logic          load_adel;
  logic          load_data;
  logic          buf_clear;
  logic [N-1:0]  buf_pc;
  logic [DW-1:0] buf_inst;

  assign aligned   = word_aligned(pc[1:0]);

  assign ibus.inst_req  = (state == S_REQ) & fpc & ~flush_except & aligned;
  assign ibus.inst_addr = pc;
  assign ibus.inst_size = SIZE_WORD;
  assign pc_en          = ibus.inst_req & ibus.inst_addr_ok & ~flush_except;

  // A misaligned pc goes straight into the buffer as an exception entry.
  assign load_adel = (state == S_REQ) & fpc & ~flush_except & ~aligned;
  assign load_data = (state == S_WAIT) & ibus.inst_data_ok & ~flush_except;
  assign buf_clear = (state == S_FULL) & (flush_except | id_allowin);
  assign buf_pc    = load_adel ? pc : pend_pc;
  assign buf_inst  = load_adel ? '0 : ibus.inst_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pend_pc <= '0;
    end else begin
      if (pc_en) pend_pc <= pc;
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (load_adel)   state <= S_FULL;
          else if (pc_en)  state <= S_WAIT;
        end
        S_WAIT: begin
          if (ibus.inst_data_ok)  state <= flush_except ? S_REQ : S_FULL;
          else if (flush_except)  state <= S_CANCEL;
        end
        S_CANCEL: begin
          if (ibus.inst_data_ok) state <= S_REQ;
        end
        S_FULL: begin
          if (buf_clear) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if_fetch_ctrl_inst_buf #(.N(N), .DW(DW)) u_inst_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_adel | load_data),
    .clear   (buf_clear),
    .ld_pc   (buf_pc),
    .ld_inst (buf_inst),
    .ld_adel (load_adel),
    .valid   (if_valid),
    .pc      (if_pc),
    .inst    (if_inst),
    .adel    (if_adel)
  );

endmodule
